// File: rtl/rot_quad_gen.sv
// Quadrature rotary-encoder emulator: turns queued CW/CCW step requests into
// Gray-coded ROTA/ROTB phases and keeps a wrapping 8-bit shadow position.
module rot_quad_gen #(
   parameter int unsigned PHASE_CYCLES = 1000,
   parameter int unsigned MAX_PENDING  = 15
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       STEP_VALID,
   input  logic       STEP_DIR,
   output logic       STEP_READY,
   output logic       ROTA,
   output logic       ROTB,
   output logic       BUSY,
   output logic [7:0] POSITION
);

   localparam int unsigned TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam int unsigned PW = 8;
   localparam logic [TW-1:0] T_LAST = TW'(PHASE_CYCLES - 1);
   localparam logic [PW-1:0] P_MAX  = PW'(MAX_PENDING);

   typedef enum logic [2:0] {
      S_IDLE,
      S_P1,
      S_P2,
      S_P3,
      S_P4
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [PW-1:0] pending_q, pending_d;
   logic          q_dir_q, q_dir_d;
   logic          s_dir_q, s_dir_d;
   logic [7:0]    pos_q, pos_d;
   logic          rota_q, rota_d;
   logic          rotb_q, rotb_d;
   logic          busy_q, busy_d;

   logic          accept;
   logic          expire;
   logic          enter_p1;

   // Queue holds one direction only; an opposite request waits for it to drain.
   assign STEP_READY = (pending_q < P_MAX) &&
                       ((pending_q == '0) || (STEP_DIR == q_dir_q));
   assign accept     = STEP_VALID && STEP_READY;
   assign expire     = (timer_q == T_LAST);

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      pending_d = pending_q;
      q_dir_d   = q_dir_q;
      s_dir_d   = s_dir_q;
      pos_d     = pos_q;
      rota_d    = 1'b0;
      rotb_d    = 1'b0;
      busy_d    = busy_q;
      enter_p1  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pending_q != '0) begin
               state_d  = S_P1;
               enter_p1 = 1'b1;
            end
         end
         S_P1: if (expire) state_d = S_P2;
         S_P2: if (expire) state_d = S_P3;
         S_P3: if (expire) state_d = S_P4;
         S_P4: begin
            if (expire) begin
               if (pending_q != '0) begin
                  state_d  = S_P1;
                  enter_p1 = 1'b1;
               end else begin
                  state_d  = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Timer restarts on every state change (including P4 -> P1) and idles at 0.
      if (state_q == S_IDLE || state_d != state_q) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end

      pending_d = pending_q + PW'(accept) - PW'(enter_p1);
      if (accept && pending_q == '0) begin
         q_dir_d = STEP_DIR;
      end

      if (enter_p1) begin
         s_dir_d = q_dir_q;
         pos_d   = q_dir_q ? (pos_q - 8'd1) : (pos_q + 8'd1);
      end

      case (state_d)
         S_P1:    {rota_d, rotb_d} = s_dir_d ? 2'b01 : 2'b10;
         S_P2:    {rota_d, rotb_d} = 2'b11;
         S_P3:    {rota_d, rotb_d} = s_dir_d ? 2'b10 : 2'b01;
         default: {rota_d, rotb_d} = 2'b00;
      endcase

      busy_d = (state_d != S_IDLE) || (pending_d != '0);
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         pending_q <= '0;
         q_dir_q   <= 1'b0;
         s_dir_q   <= 1'b0;
         pos_q     <= '0;
         rota_q    <= 1'b0;
         rotb_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         pending_q <= pending_d;
         q_dir_q   <= q_dir_d;
         s_dir_q   <= s_dir_d;
         pos_q     <= pos_d;
         rota_q    <= rota_d;
         rotb_q    <= rotb_d;
         busy_q    <= busy_d;
      end
   end

   assign ROTA     = rota_q;
   assign ROTB     = rotb_q;
   assign BUSY     = busy_q;
   assign POSITION = pos_q;

endmodule

// File: tb/tb_rot_quad_gen.sv
// Bench for rot_quad_gen: vector table for single steps plus queue, stall,
// reset and random runs checked against a step-count / position model.
module tb_rot_quad_gen;

   localparam int unsigned PC = 4;
   localparam int unsigned MP = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       step_valid;
   logic       step_dir;
   logic       step_ready;
   logic       rota;
   logic       rotb;
   logic       busy;
   logic [7:0] position;

   rot_quad_gen #(.PHASE_CYCLES(PC), .MAX_PENDING(MP)) dut (
      .CLK        (clk),
      .RSTn       (rst_n),
      .STEP_VALID (step_valid),
      .STEP_DIR   (step_dir),
      .STEP_READY (step_ready),
      .ROTA       (rota),
      .ROTB       (rotb),
      .BUSY       (busy),
      .POSITION   (position)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic       dir;
      logic [1:0] ab;
      logic [7:0] pos;
      logic       busy;
   } vec_t;

   vec_t tbl[$];

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: steps accepted vs. steps started, FIFO of directions.
   int         acc;
   int         started;
   logic       qdir_m;
   logic       q_dirs[$];
   int         pos_m;
   logic [1:0] prev_ab;
   int         dec_cnt;
   int         zero_run;
   bit         seen_full;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int mod256(input int v);
      return ((v % 256) + 256) % 256;
   endfunction

   task automatic model_clear();
      acc      = 0;
      started  = 0;
      qdir_m   = 1'b0;
      q_dirs.delete();
      pos_m    = 0;
      prev_ab  = 2'b00;
      dec_cnt  = 0;
      zero_run = 0;
   endtask

   // One clock: check READY, advance, then check outputs against the model.
   task automatic tick();
      logic       exp_ready;
      logic       will_acc;
      logic       d;
      logic [1:0] cur;
      #1;
      exp_ready = ((acc - started) < int'(MP)) && (acc == started || step_dir == qdir_m);
      if ((acc - started) >= int'(MP)) seen_full = 1'b1;
      check("step_ready", int'(step_ready), int'(exp_ready));
      will_acc = step_valid && step_ready;
      @(posedge clk);
      @(negedge clk);
      cur = {rota, rotb};
      if (will_acc) begin
         acc++;
         qdir_m = step_dir;
         q_dirs.push_back(step_dir);
      end
      check("gray_single_change", int'((prev_ab ^ cur) == 2'b11), 0);
      if (prev_ab == 2'b00 && cur != 2'b00) begin
         started++;
         if (q_dirs.size() > 0) begin
            d = q_dirs.pop_front();
            check("first_phase", int'(cur), d ? 1 : 2);
            pos_m = mod256(pos_m + (d ? -1 : 1));
         end else begin
            check("spurious_step", 1, 0);
         end
      end
      if (!prev_ab[1] && cur[1]) dec_cnt += cur[0] ? -1 : 1;
      check("position", int'(position), pos_m);
      if (cur == 2'b00 && busy) zero_run++;
      else zero_run = 0;
      check("no_gap", int'(zero_run > int'(PC)), 0);
      prev_ab = cur;
   endtask

   task automatic do_reset();
      step_valid = 1'b0;
      rst_n      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ab", int'({rota, rotb}), 0);
      check("rst_pos", int'(position), 0);
      check("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      model_clear();
      #1;
      check("rst_ready", int'(step_ready), 1);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin
         tick();
         n++;
      end
      check("idle_timeout", int'(busy), 0);
   endtask

   function automatic void add_step(input logic dir, input logic [7:0] start);
      logic [1:0] cw_seq [4];
      logic [1:0] ccw_seq[4];
      logic [7:0] np;
      vec_t       v;
      cw_seq  = '{2'b10, 2'b11, 2'b01, 2'b00};
      ccw_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
      np = dir ? start - 8'd1 : start + 8'd1;
      v = '{valid: 1'b1, dir: dir, ab: 2'b00, pos: start, busy: 1'b1};
      tbl.push_back(v);
      for (int i = 1; i <= 16; i++) begin
         v = '{valid: 1'b0, dir: dir, ab: dir ? ccw_seq[(i-1)/4] : cw_seq[(i-1)/4],
               pos: np, busy: 1'b1};
         tbl.push_back(v);
      end
      v = '{valid: 1'b0, dir: dir, ab: 2'b00, pos: np, busy: 1'b0};
      tbl.push_back(v);
   endfunction

   initial begin
      int n;
      int cw;
      int ccw;
      logic d;

      add_step(1'b1, 8'd0);
      add_step(1'b0, 8'd255);
      add_step(1'b0, 8'd0);

      step_valid = 1'b0;
      step_dir   = 1'b0;
      seen_full  = 1'b0;
      do_reset();

      // Reset in the middle of P2 abandons the step at once.
      step_valid = 1'b1;
      step_dir   = 1'b0;
      tick();
      step_valid = 1'b0;
      repeat (7) tick();
      check("mid_p2_ab", int'({rota, rotb}), 3);
      check("mid_p2_pos", int'(position), 1);
      do_reset();

      // Single-step waveforms: CCW wrap 0->255, CW 255->0, CW 0->1.
      foreach (tbl[i]) begin
         step_valid = tbl[i].valid;
         step_dir   = tbl[i].dir;
         tick();
         check("tbl_ab", int'({rota, rotb}), int'(tbl[i].ab));
         check("tbl_pos", int'(position), int'(tbl[i].pos));
         check("tbl_busy", int'(busy), int'(tbl[i].busy));
      end
      check("loopback_single", mod256(dec_cnt), 1);

      // Queue full: 300 CW steps with STEP_VALID held high.
      do_reset();
      seen_full  = 1'b0;
      step_valid = 1'b1;
      step_dir   = 1'b0;
      n = 0;
      while (acc < 300 && n < 8000) begin
         tick();
         n++;
      end
      step_valid = 1'b0;
      check("queue_accepts", acc, 300);
      check("queue_filled", int'(seen_full), 1);
      wait_idle(400);
      check("queue_pos", int'(position), 44);
      check("queue_loopback", mod256(dec_cnt), 44);

      // Direction stall: 3 CW queued, then a CCW waits until the queue drains.
      do_reset();
      step_valid = 1'b1;
      step_dir   = 1'b0;
      n = 0;
      while (acc < 3 && n < 50) begin
         tick();
         n++;
      end
      check("stall_cw_accepts", acc, 3);
      step_dir = 1'b1;
      n = 0;
      while (acc < 4 && n < 300) begin
         tick();
         n++;
      end
      step_valid = 1'b0;
      check("stall_ccw_accepted", acc, 4);
      check("stall_drained", started, 3);
      wait_idle(200);
      check("stall_pos", int'(position), 2);
      check("stall_loopback", mod256(dec_cnt), 2);

      // Random-direction run of 50 steps.
      do_reset();
      cw  = 0;
      ccw = 0;
      for (int s = 0; s < 50; s++) begin
         d          = 1'($urandom_range(0, 1));
         step_dir   = d;
         step_valid = 1'b1;
         n = acc + 1;
         for (int t = 0; t < 300 && acc < n; t++) tick();
         check("rand_accept", acc, n);
         step_valid = 1'b0;
         if (d) ccw++;
         else cw++;
         repeat ($urandom_range(0, 3)) begin
            step_dir = 1'($urandom_range(0, 1));
            tick();
         end
      end
      wait_idle(1200);
      check("rand_pos", int'(position), mod256(cw - ccw));
      check("rand_loopback", mod256(dec_cnt), mod256(cw - ccw));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
